ahb_sram_slave: RTL and testbench

- AHB-Lite responder (slave) backed by on-chip byte-writable synchronous RAM.
- Serves the core's instruction and LSU AHB master ports in simulation and FPGA builds, completing the AHB path the core initiates.
- Handles pipelined address/data phases, configurable wait states, read-after-write stalls, and the two-cycle ERROR response.

---
 rtl/ahb_sram_slave_pkg.sv | 29 ++
 rtl/ahb_sram_slave_if.sv | 26 ++
 rtl/ahb_sram_slave_mem.sv | 33 +++
 rtl/ahb_sram_slave.sv | 149 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// AHB-Lite transfer types and byte-lane helper shared by the
// SRAM responder and the core's AHB ports.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  function automatic logic [3:0] byte_en(
    input logic [2:0] size,
    input logic [1:0] lane
  );
    unique case (1'b1)
      size == HSIZE_BYTE: byte_en = 4'b0001 << lane;
      size == HSIZE_HALF: byte_en = 4'b0011 << lane;
      default:            byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite responder-side bus bundle.
// hready_i is the bus-level HREADY fed back from the decoder.
interface ahb_sram_slave_if;
  logic        hsel_i;
  logic [31:0] haddr_i;
  logic [1:0]  htrans_i;
  logic [2:0]  hsize_i;
  logic        hwrite_i;
  logic [31:0] hwdata_i;
  logic        hready_i;
  logic [31:0] hrdata_o;
  logic        hreadyout_o;
  logic        hresp_o;

  modport master (
    output hsel_i, haddr_i, htrans_i, hsize_i,
    output hwrite_i, hwdata_i, hready_i,
    input  hrdata_o, hreadyout_o, hresp_o
  );

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hsize_i,
    input  hwrite_i, hwdata_i, hready_i,
    output hrdata_o, hreadyout_o, hresp_o
  );
endinterface

// File: rtl/ahb_sram_slave_mem.sv
// Single-port byte-writable RAM with registered read data.
// Read register only updates on reads so data holds between them.
module ahb_sram_mem #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] ram [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      rdata <= '0;
    else if (en && be == 4'b0000)
      rdata <= ram[addr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder over on-chip SRAM: wait states,
// read-after-write stall and two-cycle ERROR response.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int          MEM_KB      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst,
  ahb_sram_slave_if.slave bus
);

  localparam int OW    = $clog2(MEM_KB * 1024);
  localparam int AW    = OW - 2;
  localparam int WORDS = MEM_KB * 256;
  localparam logic [2:0] W = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RAW, ST_WAIT, ST_ERR1, ST_ERR2
  } state_e;

  state_e        state;
  logic [2:0]    cnt;
  logic          wr_pend;
  logic          rdy_q;
  logic          resp_q;
  logic [OW-1:0] off_q;
  logic [2:0]    size_q;

  logic [31:0]   off;
  logic          accept;
  logic          misal;
  logic          err;
  logic          ok_acc;
  logic          commit;
  logic          raw;
  logic          mem_en;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  assign off    = bus.haddr_i - BASE_ADDR;
  assign accept = rst & bus.hsel_i & bus.hready_i &
                  ((bus.htrans_i == HTRANS_NONSEQ) |
                   (bus.htrans_i == HTRANS_SEQ));
  assign misal  = ((bus.hsize_i == HSIZE_HALF) & bus.haddr_i[0]) |
                  ((bus.hsize_i == HSIZE_WORD) & (|bus.haddr_i[1:0]));
  assign err    = (off >= 32'(MEM_KB * 1024)) |
                  (bus.hsize_i > HSIZE_WORD) | misal;
  assign ok_acc = accept & ~err;

  // Writes land on the edge that closes their data phase.
  assign commit = rst & wr_pend & rdy_q;
  assign raw    = ok_acc & ~bus.hwrite_i & commit;

  assign mem_en = commit | (ok_acc & ~bus.hwrite_i) |
                  (state == ST_RAW);
  assign mem_be = commit ? byte_en(size_q, off_q[1:0]) : 4'b0000;
  assign mem_addr = (commit || state == ST_RAW) ?
                    off_q[OW-1:2] : off[OW-1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      wr_pend <= 1'b0;
      rdy_q   <= 1'b1;
      resp_q  <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      if (commit) wr_pend <= 1'b0;
      if (ok_acc) begin
        off_q  <= off[OW-1:0];
        size_q <= bus.hsize_i;
        if (bus.hwrite_i) wr_pend <= 1'b1;
      end
      unique case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept && err) begin
            state  <= ST_ERR1;
            rdy_q  <= 1'b0;
            resp_q <= 1'b1;
          end else if (raw) begin
            state  <= ST_RAW;
            rdy_q  <= 1'b0;
            resp_q <= 1'b0;
          end else if (ok_acc && W != 3'd0) begin
            state  <= ST_WAIT;
            cnt    <= W;
            rdy_q  <= 1'b0;
            resp_q <= 1'b0;
          end else begin
            state  <= ST_IDLE;
            rdy_q  <= 1'b1;
            resp_q <= 1'b0;
          end
        end
        ST_RAW: begin
          if (W != 3'd0) begin
            state <= ST_WAIT;
            cnt   <= W;
          end else begin
            state <= ST_IDLE;
            rdy_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd1) begin
            state <= ST_IDLE;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state  <= ST_ERR2;
          rdy_q  <= 1'b1;
          resp_q <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          rdy_q  <= 1'b1;
          resp_q <= 1'b0;
        end
      endcase
    end
  end

  ahb_sram_mem #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (bus.hwdata_i),
    .rdata (mem_rdata)
  );

  assign bus.hrdata_o    = mem_rdata;
  assign bus.hreadyout_o = rdy_q;
  assign bus.hresp_o     = resp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one zero-wait and one 3-wait instance,
// pipelined AHB driver with an expected-response queue.
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_slave_if b0();
  ahb_sram_slave_if b3();

  logic        dsel;
  logic        stall;
  logic        hsel;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        rdy;
  logic        resp;
  logic [31:0] rdata;

  assign b0.hsel_i    = hsel & ~dsel;
  assign b0.htrans_i  = dsel ? 2'b00 : htrans;
  assign b0.haddr_i   = haddr;
  assign b0.hsize_i   = hsize;
  assign b0.hwrite_i  = hwrite;
  assign b0.hwdata_i  = hwdata;
  assign b0.hready_i  = b0.hreadyout_o & ~stall;

  assign b3.hsel_i    = hsel & dsel;
  assign b3.htrans_i  = dsel ? htrans : 2'b00;
  assign b3.haddr_i   = haddr;
  assign b3.hsize_i   = hsize;
  assign b3.hwrite_i  = hwrite;
  assign b3.hwdata_i  = hwdata;
  assign b3.hready_i  = b3.hreadyout_o & ~stall;

  assign rdy   = dsel ? b3.hreadyout_o : b0.hreadyout_o;
  assign resp  = dsel ? b3.hresp_o     : b0.hresp_o;
  assign rdata = dsel ? b3.hrdata_o    : b0.hrdata_o;

  ahb_sram_slave #(
    .MEM_KB(16), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  ahb_sram_slave #(
    .MEM_KB(16), .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  typedef struct {
    bit          rd;
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [2][1024];

  int          n_ops = 0;
  bit          o_wr   [16];
  logic [31:0] o_addr [16];
  logic [2:0]  o_size [16];
  logic [31:0] o_wd   [16];

  function automatic bit is_err(logic [31:0] a, logic [2:0] s);
    return (a >= 32'h4000) || (s > 3'd2) ||
           (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
      logic [31:0] d, logic [2:0] s, logic [1:0] a);
    logic [31:0] r;
    bit hit;
    r = old;
    for (int b = 0; b < 4; b++) begin
      hit = (s == 3'd2) || (s == 3'd0 && b == int'(a)) ||
            (s == 3'd1 && (b == int'(a) || b == int'(a) + 1));
      if (hit) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic add(bit wr, logic [31:0] a, logic [2:0] s,
                     logic [31:0] d);
    o_wr[n_ops]   = wr;
    o_addr[n_ops] = a;
    o_size[n_ops] = s;
    o_wd[n_ops]   = d;
    n_ops++;
  endtask

  // Pipelined driver: address of op i overlaps data phase of op i-1.
  task automatic run_ops();
    int   pend;
    bit   prev_wr_ok;
    bit   er;
    int   w;
    int   wst;
    int   d;
    exp_t e;
    pend = -1;
    prev_wr_ok = 0;
    wst = dsel ? 3 : 0;
    d = dsel ? 1 : 0;
    for (int i = 0; i <= n_ops; i++) begin
      if (i < n_ops) begin
        hsel = 1'b1; htrans = 2'b10; haddr = o_addr[i];
        hsize = o_size[i]; hwrite = o_wr[i];
        er = is_err(o_addr[i], o_size[i]);
        e.rd = !er && !o_wr[i];
        e.resp = er;
        e.data = 32'h0;
        e.waits = er ? 1 :
          wst + ((!o_wr[i] && prev_wr_ok) ? 1 : 0);
        if (!er && o_wr[i])
          mdl[d][o_addr[i][11:2]] = merge(mdl[d][o_addr[i][11:2]],
            o_wd[i], o_size[i], o_addr[i][1:0]);
        if (e.rd) e.data = mdl[d][o_addr[i][11:2]];
        prev_wr_ok = !er && o_wr[i];
        sb.push_back(e);
      end else begin
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0;
        hsize = 3'd0; hwrite = 1'b0;
      end
      hwdata = (pend >= 0) ? o_wd[pend] : 32'h0;
      if (pend >= 0) begin
        e = sb.pop_front();
        w = 0;
        @(negedge clk);
        while (rdy !== 1'b1 && w < 20) begin
          checks++;
          if (resp !== e.resp) begin
            errors++;
            $display("FAIL resp_wait a=%h: got %b want %b",
                     o_addr[pend], resp, e.resp);
          end
          w++;
          @(negedge clk);
        end
        checks++;
        if (w !== e.waits) begin
          errors++;
          $display("FAIL waits a=%h: got %0d want %0d",
                   o_addr[pend], w, e.waits);
        end
        checks++;
        if (resp !== e.resp) begin
          errors++;
          $display("FAIL resp a=%h: got %b want %b",
                   o_addr[pend], resp, e.resp);
        end
        if (e.rd) begin
          checks++;
          if (rdata !== e.data) begin
            errors++;
            $display("FAIL rdata a=%h: got %h want %h",
                     o_addr[pend], rdata, e.data);
          end
        end
      end else begin
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      pend = i;
    end
    hwdata = 32'h0;
    n_ops = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dsel = k[0];
      #0;
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_rdy dut%0d: got %b want 1", k, rdy);
      end
      checks++;
      if (resp !== 1'b0) begin
        errors++;
        $display("FAIL reset_resp dut%0d: got %b want 0", k, resp);
      end
      checks++;
      if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata dut%0d: got %h want 0", k, rdata);
      end
    end
    dsel = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    dsel = 1'b0;
    add(1, 32'h10, 3'd2, 32'hDEADBEEF);
    add(0, 32'h10, 3'd2, 32'h0);
    run_ops();
  endtask

  task automatic test_lanes();
    dsel = 1'b0;
    add(1, 32'h20, 3'd2, 32'h0);
    add(1, 32'h21, 3'd0, 32'h0000AA00);
    add(1, 32'h22, 3'd1, 32'h12340000);
    add(0, 32'h20, 3'd2, 32'h0);
    run_ops();
    checks++;
    if (mdl[0][8] !== 32'h1234AA00) begin
      errors++;
      $display("FAIL lane_model: got %h want 1234aa00", mdl[0][8]);
    end
  endtask

  task automatic test_errors();
    dsel = 1'b0;
    add(1, 32'h0, 3'd2, 32'hCAFEF00D);
    add(1, 32'h3, 3'd1, 32'h55660000);
    add(0, 32'h4000, 3'd2, 32'h0);
    add(1, 32'h4, 3'd3, 32'h77777777);
    add(0, 32'h0, 3'd2, 32'h0);
    run_ops();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    dsel = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v = $urandom;
      add(1, 32'h40 + 32'(4 * k), 3'd2, v);
    end
    for (int k = 0; k < 3; k++)
      add(0, 32'h40 + 32'(4 * k), 3'd2, 32'h0);
    add(1, 32'h4C, 3'd2, 32'h0BADCAFE);
    add(1, 32'h50, 3'd2, 32'h13579BDF);
    add(0, 32'h4C, 3'd2, 32'h0);
    run_ops();
  endtask

  task automatic test_wait_states();
    dsel = 1'b1;
    add(1, 32'h8, 3'd2, 32'h55AA55AA);
    add(0, 32'h8, 3'd2, 32'h0);
    run_ops();
    add(0, 32'h8, 3'd2, 32'h0);
    run_ops();
  endtask

  task automatic test_stall_idle();
    dsel = 1'b1;
    stall = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h8;
    hsize = 3'd2; hwrite = 1'b1; hwdata = 32'h99999999;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL stall_rdy cyc%0d: got %b want 1", k, rdy);
      end
    end
    hsel = 1'b1; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0;
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || resp !== 1'b0) begin
      errors++;
      $display("FAIL idle_okay: got rdy=%b resp=%b want 1/0",
               rdy, resp);
    end
    checks++;
    if (rdata !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL idle_hold: got %h want 55aa55aa", rdata);
    end
    hsel = 1'b0;
    @(posedge clk);
    #1;
    add(0, 32'h8, 3'd2, 32'h0);
    run_ops();
  endtask

  task automatic test_reset_mid_write();
    dsel = 1'b1;
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h8;
    hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hwdata = 32'h11111111;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_rdy: got %b want 0", rdy);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || resp !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_out: got %b/%b/%h want 1/0/0",
               rdy, resp, rdata);
    end
    rst = 1'b1;
    hwdata = 32'h0;
    @(posedge clk);
    #1;
    add(0, 32'h8, 3'd2, 32'h0);
    run_ops();
  endtask

  initial begin
    dsel = 1'b0; stall = 1'b0; hsel = 1'b0; hwrite = 1'b0;
    htrans = 2'b00; hsize = 3'd0; haddr = 32'h0; hwdata = 32'h0;
    test_reset();
    test_write_read();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_stall_idle();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
